// File: rtl/serial_out_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_out_sequencer
// Purpose  : Upstream feeder for diff_freq_serial_out. Queues {freq_sel, data}
//            frames from a host in a small FIFO and issues them one at a time:
//            drives data/frequency select, pulses start, waits for the
//            serializer's done tick, then holds an optional idle gap.
//            Supports abort (flush + stop) and status/overflow reporting.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            i_wr_en/freq/data - host frame push
//            i_abort           - flush FIFO, stop serializer, back to idle
//            i_done_tick       - serializer frame-complete tick
//            o_sel_freq/o_data/o_start/o_stop - serializer control
//            o_busy/o_full/o_empty/o_count/o_overflow - status
// Revision : 1.0 - initial release
// ============================================================================
module serial_out_sequencer #(
    parameter int DATA_BIT   = 16,
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_en,
    input  logic                         i_wr_freq,
    input  logic [DATA_BIT-1:0]          i_wr_data,
    input  logic                         i_abort,
    input  logic                         i_done_tick,
    output logic                         o_sel_freq,
    output logic [DATA_BIT-1:0]          o_data,
    output logic                         o_start,
    output logic                         o_stop,
    output logic                         o_busy,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_overflow
);

    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W:0] c_depth   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_cnt_one = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);
    localparam logic            c_has_gap = (GAP_CYCLES > 0);
    localparam logic [15:0]     c_gap_last = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_start = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_gap   = 3'd4;

    // Each entry stores {freq_sel, data}.
    logic [DATA_BIT:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;

    logic [2:0]          r_state;
    logic [15:0]         r_gap_cnt;
    logic [DATA_BIT-1:0] r_data;
    logic                r_sel_freq;
    logic                r_stop;

    logic                w_room;
    logic                w_push;
    logic                w_pop;

    // Room is judged on the registered count only: a pop in the same cycle
    // never makes space for a write to a full FIFO.
    assign w_room = (r_count < c_depth);
    assign w_push = i_wr_en && w_room && !i_abort;
    assign w_pop  = (r_state == c_st_load) && !i_abort;

    // Storage array carries no reset; only valid entries are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_wr_freq, i_wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_abort) begin
            // Flush; a same-cycle write is silently discarded.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_wr_en && !w_room;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_gap_cnt  <= 16'd0;
            r_data     <= '0;
            r_sel_freq <= 1'b0;
            r_stop     <= 1'b0;
        end else if (i_abort) begin
            // Only a frame that has been started needs the serializer stopped.
            r_stop    <= (r_state == c_st_start) || (r_state == c_st_wait);
            r_state   <= c_st_idle;
            r_gap_cnt <= 16'd0;
        end else begin
            r_stop <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (r_count != '0) begin
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
                    {r_sel_freq, r_data} <= r_mem[r_rd_ptr];
                    r_state <= c_st_start;
                end
                c_st_start: begin
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (i_done_tick) begin
                        r_gap_cnt <= 16'd0;
                        r_state   <= c_has_gap ? c_st_gap : c_st_idle;
                    end
                end
                c_st_gap: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_gap_cnt <= 16'd0;
                        r_state   <= c_st_idle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign o_sel_freq = r_sel_freq;
    assign o_data     = r_data;
    assign o_start    = (r_state == c_st_start);
    assign o_stop     = r_stop;
    assign o_busy     = (r_state != c_st_idle);
    assign o_full     = (r_count == c_depth);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_out_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_out_sequencer
// Purpose  : Directed self-checking bench for serial_out_sequencer; a second
//            instance is built with GAP_CYCLES=0 for the no-gap timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_out_sequencer;

    logic        clk;
    logic        rst;
    logic        wr_en, wr_freq, abort, done_tick;
    logic [15:0] wr_data;
    logic        sel_freq, start, stop, busy, full, empty, overflow;
    logic [15:0] data;
    logic [3:0]  count;

    logic        wr_en0, wr_freq0, abort0, done_tick0;
    logic [15:0] wr_data0;
    logic        sel_freq0, start0, stop0, busy0, full0, empty0, overflow0;
    logic [15:0] data0;
    logic [3:0]  count0;

    int n_checks = 0;
    int n_errors = 0;

    serial_out_sequencer #(.DATA_BIT(16), .DEPTH(8), .GAP_CYCLES(100)) u_dut (
        .clk(clk), .rst(rst),
        .i_wr_en(wr_en), .i_wr_freq(wr_freq), .i_wr_data(wr_data),
        .i_abort(abort), .i_done_tick(done_tick),
        .o_sel_freq(sel_freq), .o_data(data), .o_start(start), .o_stop(stop),
        .o_busy(busy), .o_full(full), .o_empty(empty), .o_count(count),
        .o_overflow(overflow)
    );

    serial_out_sequencer #(.DATA_BIT(16), .DEPTH(8), .GAP_CYCLES(0)) u_dut_nogap (
        .clk(clk), .rst(rst),
        .i_wr_en(wr_en0), .i_wr_freq(wr_freq0), .i_wr_data(wr_data0),
        .i_abort(abort0), .i_done_tick(done_tick0),
        .o_sel_freq(sel_freq0), .o_data(data0), .o_start(start0), .o_stop(stop0),
        .o_busy(busy0), .o_full(full0), .o_empty(empty0), .o_count(count0),
        .o_overflow(overflow0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples both sit 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag, input bit nogap);
        int n = 0;
        while (!(nogap ? start0 : start) && n < 300) begin
            tick();
            n++;
        end
        check_val(tag, nogap ? start0 : start, 1);
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 0; wr_freq = 0; wr_data = 0; abort = 0; done_tick = 0;
        wr_en0 = 0; wr_freq0 = 0; wr_data0 = 0; abort0 = 0; done_tick0 = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset values
        check_val("rst_busy", busy, 0);
        check_val("rst_empty", empty, 1);
        check_val("rst_full", full, 0);
        check_val("rst_count", count, 0);
        check_val("rst_start", start, 0);
        check_val("rst_data", data, 0);
        check_val("rst_sel", sel_freq, 0);

        // 1: single frame latency and gap length
        wr_en = 1; wr_freq = 1; wr_data = 16'hA5C3;
        tick();
        wr_en = 0;
        check_val("t1_count1", count, 1);
        check_val("t1_idle", busy, 0);
        tick();
        check_val("t1_load_busy", busy, 1);
        check_val("t1_load_nostart", start, 0);
        tick();
        check_val("t1_start", start, 1);
        check_val("t1_data", data, 16'hA5C3);
        check_val("t1_sel", sel_freq, 1);
        check_val("t1_popped", count, 0);
        tick();
        check_val("t1_start_pulse", start, 0);
        repeat (5) tick();
        check_val("t1_data_hold", data, 16'hA5C3);
        done_tick = 1;
        tick();
        done_tick = 0;
        check_val("t1_gap_busy", busy, 1);
        repeat (99) tick();
        check_val("t1_gap_last", busy, 1);
        tick();
        check_val("t1_gap_done", busy, 0);
        check_val("t1_retain", data, 16'hA5C3);

        // 2/3: primer frame parked in WAIT, then burst to full
        wr_en = 1; wr_freq = 0; wr_data = 16'h00FF;
        tick();
        wr_en = 0;
        wait_start("t2_primer_start", 0);
        check_val("t2_primer_data", data, 16'h00FF);
        tick();
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1; wr_data = 16'(i); wr_freq = i[0];
            tick();
        end
        wr_en = 0;
        check_val("t2_full", full, 1);
        check_val("t2_count8", count, 8);
        wr_en = 1; wr_data = 16'h0009;
        tick();
        wr_en = 0;
        check_val("t2_ovf", overflow, 1);
        check_val("t2_count_stay", count, 8);
        tick();
        check_val("t2_ovf_pulse", overflow, 0);
        done_tick = 1;
        tick();
        done_tick = 0;
        repeat (100) tick();
        check_val("t3_idle", busy, 0);
        tick();
        check_val("t3_load", busy, 1);
        wr_en = 1; wr_data = 16'hDEAD; wr_freq = 0;
        tick();
        wr_en = 0;
        check_val("t3_ovf", overflow, 1);
        check_val("t3_count7", count, 7);
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) wait_start($sformatf("t2_start%0d", i), 0);
            check_val($sformatf("t2_data%0d", i), data, i);
            check_val($sformatf("t2_sel%0d", i), sel_freq, i % 2);
            tick();
            done_tick = 1;
            tick();
            done_tick = 0;
        end
        repeat (101) tick();
        check_val("t2_end_idle", busy, 0);
        check_val("t2_end_empty", empty, 1);
        check_val("t2_end_retain", data, 8);

        // 4: abort in WAIT with five frames queued
        for (int i = 0; i < 6; i++) begin
            wr_en = 1; wr_data = 16'h0100 + 16'(i); wr_freq = 1;
            tick();
        end
        wr_en = 0;
        check_val("t4_count5", count, 5);
        check_val("t4_waiting", busy, 1);
        abort = 1;
        tick();
        abort = 0;
        check_val("t4_stop", stop, 1);
        check_val("t4_count0", count, 0);
        check_val("t4_idle", busy, 0);
        done_tick = 1;
        tick();
        done_tick = 0;
        check_val("t4_stop_pulse", stop, 0);
        check_val("t4_done_ignored", busy, 0);
        tick();
        check_val("t4_still_idle", busy, 0);

        // 5: abort in GAP, then abort + write in IDLE
        wr_en = 1; wr_data = 16'h0BEE; wr_freq = 0;
        tick();
        wr_en = 0;
        wait_start("t5_start", 0);
        tick();
        done_tick = 1;
        tick();
        done_tick = 0;
        repeat (5) tick();
        check_val("t5_in_gap", busy, 1);
        abort = 1;
        tick();
        abort = 0;
        check_val("t5_gap_nostop", stop, 0);
        check_val("t5_gap_idle", busy, 0);
        abort = 1; wr_en = 1; wr_data = 16'h1234;
        tick();
        abort = 0; wr_en = 0;
        check_val("t5_idle_nostop", stop, 0);
        check_val("t5_aw_count", count, 0);
        check_val("t5_aw_noovf", overflow, 0);
        tick();
        check_val("t5_aw_stay_idle", busy, 0);

        // 6: GAP_CYCLES=0 build, next start three cycles after done
        wr_en0 = 1; wr_data0 = 16'h0C01; wr_freq0 = 1;
        tick();
        wr_data0 = 16'h0C02; wr_freq0 = 0;
        tick();
        wr_en0 = 0;
        wait_start("t6_start1", 1);
        check_val("t6_data1", data0, 16'h0C01);
        tick();
        done_tick0 = 1;
        tick();
        done_tick0 = 0;
        check_val("t6_idle", busy0, 0);
        tick();
        check_val("t6_load_nostart", start0, 0);
        tick();
        check_val("t6_start2", start0, 1);
        check_val("t6_data2", data0, 16'h0C02);
        check_val("t6_sel2", sel_freq0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
